// File: rtl/axi_burst_dma_if.sv
// AXI4 read/write channel bundle for the burst DMA.
// Size, burst type and write strobes are not carried; the fabric-side
// wrapper ties them to full-width beats, INCR bursts and all-ones strobes.
//
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where VALID and READY are both high. Once the source raises VALID, it holds
// VALID and its payload stable until that edge. READY may change at any time.
interface axi_burst_dma_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arlen, arvalid, input arready,
        input  rdata, rresp, rlast, rvalid, output rready,
        output awaddr, awlen, awvalid, input awready,
        output wdata, wlast, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arlen, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready,
        input  awaddr, awlen, awvalid, output awready,
        input  wdata, wlast, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_burst_dma.sv
// Single-channel memory-to-memory DMA moving data in AXI4 INCR bursts.
// A read engine fills an internal FIFO and a write engine drains it; each
// engine splits its own bursts at MAX_BURST and at 4 KB page boundaries.
module axi_burst_dma #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_beats,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_resp,
    output logic [1:0]        rd_state_dbg,
    output logic [1:0]        wr_state_dbg,
    axi_burst_dma_if.master   axi
);
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int BW      = 5;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);
    localparam logic [PTR_W:0]    DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;

    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [LEN_W-1:0]  rd_rem, wr_rem;
    logic [BW-1:0]     rd_beats, wr_beats;
    logic [BW-1:0]     rd_burst, wr_burst, wr_idx;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  fifo_wptr, fifo_rptr;
    logic [PTR_W:0]    fifo_count, fifo_space;

    logic accept, push, pop, b_fire;
    logic rd_room, wr_room, rd_last_burst, wr_last_burst, wr_is_last, wr_final;

    // Beats for the next burst: capped by MAX_BURST, the remaining length and the 4 KB page end.
    function automatic logic [BW-1:0] burst_beats(input logic [11:0] page_off,
                                                  input logic [LEN_W-1:0] remaining);
        logic [12:0]   to_bnd;
        logic [BW-1:0] beats;
        to_bnd = (13'h1000 - {1'b0, page_off}) >> BYTE_SH;
        beats  = BW'(MAX_BURST);
        if (to_bnd < {8'd0, beats}) beats = to_bnd[BW-1:0];
        if (remaining < LEN_W'(beats)) beats = remaining[BW-1:0];
        return beats;
    endfunction

    assign accept        = start && !busy;
    assign rd_beats      = burst_beats(rd_addr[11:0], rd_rem);
    assign wr_beats      = burst_beats(wr_addr[11:0], wr_rem);
    assign fifo_space    = DEPTH_C - fifo_count;
    // Read only when the whole burst fits; write only when the whole burst is buffered.
    assign rd_room       = 8'(fifo_space) >= 8'(rd_beats);
    assign wr_room       = 8'(fifo_count) >= 8'(wr_beats);
    assign rd_last_burst = rd_rem == LEN_W'(rd_burst);
    assign wr_last_burst = wr_rem == LEN_W'(wr_burst);
    assign wr_is_last    = wr_idx == (wr_burst - BW'(1));
    assign push          = (rd_state == RD_DATA) && axi.rvalid;
    assign pop           = (wr_state == WR_DATA) && axi.wready;
    assign b_fire        = (wr_state == WR_RESP) && axi.bvalid;
    assign wr_final      = b_fire && wr_last_burst;
    assign axi.wdata     = fifo_mem[fifo_rptr];
    assign rd_state_dbg  = rd_state;
    assign wr_state_dbg  = wr_state;

    // Read FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_state <= RD_IDLE;
        else       rd_state <= rd_next;
    end

    // Read FSM next state and AR/R outputs.
    always_comb begin
        rd_next     = rd_state;
        axi.arvalid = 1'b0;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.rready  = 1'b0;
        case (rd_state)
            RD_IDLE: if (accept && len_beats != '0) rd_next = RD_ADDR;
            RD_ADDR: begin
                axi.araddr  = rd_addr;
                axi.arlen   = 8'(rd_beats - BW'(1));
                axi.arvalid = rd_room;
                if (rd_room && axi.arready) rd_next = RD_DATA;
            end
            RD_DATA: begin
                axi.rready = 1'b1;
                if (axi.rvalid && axi.rlast) rd_next = rd_last_burst ? RD_IDLE : RD_ADDR;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Read address/length bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr  <= '0;
            rd_rem   <= '0;
            rd_burst <= '0;
        end else if (accept) begin
            rd_addr <= src_addr & ALIGN_MASK;
            rd_rem  <= len_beats;
        end else begin
            if (rd_state == RD_ADDR && rd_room && axi.arready) rd_burst <= rd_beats;
            if (push && axi.rlast) begin
                rd_addr <= rd_addr + (ADDR_W'(rd_burst) << BYTE_SH);
                rd_rem  <= rd_rem - LEN_W'(rd_burst);
            end
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_state <= WR_IDLE;
        else       wr_state <= wr_next;
    end

    // Write FSM next state and AW/W/B outputs.
    always_comb begin
        wr_next     = wr_state;
        axi.awvalid = 1'b0;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        axi.bready  = 1'b0;
        case (wr_state)
            WR_IDLE: if (accept && len_beats != '0) wr_next = WR_ADDR;
            WR_ADDR: begin
                axi.awaddr  = wr_addr;
                axi.awlen   = 8'(wr_beats - BW'(1));
                axi.awvalid = wr_room;
                if (wr_room && axi.awready) wr_next = WR_DATA;
            end
            WR_DATA: begin
                axi.wvalid = 1'b1;
                axi.wlast  = wr_is_last;
                if (axi.wready && wr_is_last) wr_next = WR_RESP;
            end
            WR_RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) wr_next = wr_last_burst ? WR_IDLE : WR_ADDR;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Write address/length and beat counter bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr  <= '0;
            wr_rem   <= '0;
            wr_burst <= '0;
            wr_idx   <= '0;
        end else if (accept) begin
            wr_addr <= dst_addr & ALIGN_MASK;
            wr_rem  <= len_beats;
        end else begin
            if (wr_state == WR_ADDR && wr_room && axi.awready) begin
                wr_burst <= wr_beats;
                wr_idx   <= '0;
            end
            if (pop) wr_idx <= wr_idx + BW'(1);
            if (b_fire) begin
                wr_addr <= wr_addr + (ADDR_W'(wr_burst) << BYTE_SH);
                wr_rem  <= wr_rem - LEN_W'(wr_burst);
            end
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wptr  <= '0;
            fifo_rptr  <= '0;
            fifo_count <= '0;
        end else begin
            if (push) fifo_wptr <= fifo_wptr + PTR_W'(1);
            if (pop)  fifo_rptr <= fifo_rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; the head is always presented on WDATA.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[fifo_wptr] <= axi.rdata;
    end

    // Transfer status: busy/done, and sticky error with the first bad response code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_resp <= 2'b00;
        end else begin
            done <= 1'b0;
            if (accept) begin
                error    <= 1'b0;
                err_resp <= 2'b00;
                if (len_beats == '0) done <= 1'b1;
                else                 busy <= 1'b1;
            end else begin
                if (wr_final) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                if (!error) begin
                    if (push && axi.rresp != 2'b00) begin
                        error    <= 1'b1;
                        err_resp <= axi.rresp;
                    end else if (b_fire && axi.bresp != 2'b00) begin
                        error    <= 1'b1;
                        err_resp <= axi.bresp;
                    end
                end
            end
        end
    end

    // Space is reserved before a read burst and data buffered before a write burst,
    // so the FIFO can never overflow or underflow.
    assert property (@(posedge clk) disable iff (reset) !(push && fifo_count == DEPTH_C));
    assert property (@(posedge clk) disable iff (reset) !(pop && fifo_count == '0));
endmodule

// File: tb/tb_axi_burst_dma.sv
// Directed testbench for axi_burst_dma with a negedge-driven AXI memory slave.
module tb_axi_burst_dma;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len_beats;
    logic        busy, done, error;
    logic [1:0]  err_resp;
    logic [1:0]  rd_state_dbg, wr_state_dbg;

    axi_burst_dma_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_burst_dma #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(16), .FIFO_DEPTH(16), .MAX_BURST(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len_beats(len_beats), .busy(busy), .done(done),
        .error(error), .err_resp(err_resp), .rd_state_dbg(rd_state_dbg),
        .wr_state_dbg(wr_state_dbg), .axi(axi)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Slave model state and logs
    logic [39:0] ar_log[$], aw_log[$], rq[$], awq[$];
    logic [31:0] wmem [logic [31:0]];
    int r_beat = 0, w_beat = 0, b_pending = 0, b_count = 0;
    int err_b_idx = -1, w_stall = 0, wlast_bad = 0, done_cnt = 0;

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // AXI slave: inputs set on the falling edge, handshakes recorded for the next rising edge.
    initial begin
        logic [39:0] cur;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rq.delete(); awq.delete();
                r_beat = 0; w_beat = 0; b_pending = 0;
                axi.arready = 0; axi.rvalid = 0; axi.rlast = 0;
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
            end else begin
                axi.bvalid = (b_pending > 0);
                axi.bresp  = (b_count == err_b_idx) ? 2'b10 : 2'b00;
                if (axi.bvalid && axi.bready) begin
                    b_pending--;
                    b_count++;
                end
                axi.wready = (w_stall == 0);
                if (w_stall > 0) w_stall--;
                if (axi.wvalid && axi.wready) begin
                    if (awq.size() == 0) wlast_bad++;
                    else begin
                        cur = awq[0];
                        wmem[cur[39:8] + 32'(w_beat) * 32'd4] = axi.wdata;
                        if (axi.wlast != (w_beat == int'(cur[7:0]))) wlast_bad++;
                        if (w_beat == int'(cur[7:0])) begin
                            void'(awq.pop_front());
                            w_beat = 0;
                            b_pending++;
                        end else w_beat++;
                    end
                end
                axi.awready = 1;
                if (axi.awvalid) begin
                    aw_log.push_back({axi.awaddr, axi.awlen});
                    awq.push_back({axi.awaddr, axi.awlen});
                end
                if (rq.size() > 0) begin
                    cur = rq[0];
                    axi.rvalid = 1;
                    axi.rresp  = 2'b00;
                    axi.rdata  = src_word(cur[39:8] + 32'(r_beat) * 32'd4);
                    axi.rlast  = (r_beat == int'(cur[7:0]));
                    if (axi.rready) begin
                        if (axi.rlast) begin
                            void'(rq.pop_front());
                            r_beat = 0;
                        end else r_beat++;
                    end
                end else begin
                    axi.rvalid = 0;
                    axi.rlast  = 0;
                end
                axi.arready = 1;
                if (axi.arvalid) begin
                    ar_log.push_back({axi.araddr, axi.arlen});
                    rq.push_back({axi.araddr, axi.arlen});
                end
            end
        end
    end

    // Done pulse counter
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
    end

    // Driver tasks
    task automatic clear_logs();
        ar_log.delete(); aw_log.delete(); wmem.delete();
        err_b_idx = -1; b_count = 0; wlast_bad = 0;
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        src_addr = s; dst_addr = d; len_beats = l; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_done: done=%0b required 1 within 3000 cycles", name, done);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_at_done: busy=%0b required 0", name, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse: done=%0b required 0 one cycle later", name, done);
        end
    endtask

    // Test tasks
    task automatic test_reset();
        reset = 1; start = 0; src_addr = 0; dst_addr = 0; len_beats = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, err_resp, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid,
             axi.bready, axi.araddr, axi.arlen, axi.awaddr, axi.awlen} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%0b done=%0b error=%0b arvalid=%0b rready=%0b awvalid=%0b wvalid=%0b bready=%0b araddr=%h awaddr=%h required all 0",
                     busy, done, error, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, axi.araddr, axi.awaddr);
        end
        reset = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, axi.arvalid, axi.awvalid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%0b done=%0b arvalid=%0b awvalid=%0b required 0", busy, done, axi.arvalid, axi.awvalid);
        end
    endtask

    task automatic test_single();
        clear_logs();
        start_xfer(32'h1000, 32'h2000, 16'd1);
        wait_done("single");
        checks++;
        if (ar_log.size() != 1 || ar_log[0] !== {32'h1000, 8'd0}) begin
            failures++;
            $display("FAIL single_ar: count=%0d first=%h required 1 entry 0000100000", ar_log.size(), ar_log.size() ? ar_log[0] : 40'h0);
        end
        checks++;
        if (aw_log.size() != 1 || aw_log[0] !== {32'h2000, 8'd0}) begin
            failures++;
            $display("FAIL single_aw: count=%0d first=%h required 1 entry 0000200000", aw_log.size(), aw_log.size() ? aw_log[0] : 40'h0);
        end
        checks++;
        if (!wmem.exists(32'h2000) || wmem[32'h2000] !== src_word(32'h1000)) begin
            failures++;
            $display("FAIL single_data: got=%h required %h", wmem.exists(32'h2000) ? wmem[32'h2000] : 32'hx, src_word(32'h1000));
        end
    endtask

    task automatic test_multi_burst();
        logic [39:0] exp_ar[$], exp_aw[$];
        logic [31:0] a;
        exp_ar = '{{32'h1000, 8'd7}, {32'h1020, 8'd7}, {32'h1040, 8'd3}};
        exp_aw = '{{32'h3000, 8'd7}, {32'h3020, 8'd7}, {32'h3040, 8'd3}};
        clear_logs();
        start_xfer(32'h1000, 32'h3000, 16'd20);
        wait_done("multi");
        checks++;
        if (ar_log.size() != 3 || aw_log.size() != 3) begin
            failures++;
            $display("FAIL multi_burst_count: ar=%0d aw=%0d required 3 and 3", ar_log.size(), aw_log.size());
        end
        for (int i = 0; i < 3 && i < ar_log.size() && i < aw_log.size(); i++) begin
            checks++;
            if (ar_log[i] !== exp_ar[i] || aw_log[i] !== exp_aw[i]) begin
                failures++;
                $display("FAIL multi_burst_%0d: ar=%h aw=%h required ar=%h aw=%h", i, ar_log[i], aw_log[i], exp_ar[i], exp_aw[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            a = 32'h3000 + 32'(i) * 4;
            checks++;
            if (!wmem.exists(a) || wmem[a] !== src_word(32'h1000 + 32'(i) * 4)) begin
                failures++;
                $display("FAIL multi_data_%0d: got=%h required %h", i, wmem.exists(a) ? wmem[a] : 32'hx, src_word(32'h1000 + 32'(i) * 4));
            end
        end
        checks++;
        if (wlast_bad != 0) begin
            failures++;
            $display("FAIL multi_wlast: bad beats=%0d required 0", wlast_bad);
        end
    endtask

    task automatic test_4k_split();
        logic [39:0] exp_ar[$], exp_aw[$];
        logic [31:0] a;
        exp_ar = '{{32'h0FF8, 8'd1}, {32'h1000, 8'd5}};
        exp_aw = '{{32'h1FF0, 8'd3}, {32'h2000, 8'd3}};
        clear_logs();
        start_xfer(32'h0FF8, 32'h1FF0, 16'd8);
        wait_done("split");
        checks++;
        if (ar_log.size() != 2 || aw_log.size() != 2) begin
            failures++;
            $display("FAIL split_count: ar=%0d aw=%0d required 2 and 2", ar_log.size(), aw_log.size());
        end
        for (int i = 0; i < 2 && i < ar_log.size() && i < aw_log.size(); i++) begin
            checks++;
            if (ar_log[i] !== exp_ar[i] || aw_log[i] !== exp_aw[i]) begin
                failures++;
                $display("FAIL split_burst_%0d: ar=%h aw=%h required ar=%h aw=%h", i, ar_log[i], aw_log[i], exp_ar[i], exp_aw[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            a = 32'h1FF0 + 32'(i) * 4;
            checks++;
            if (!wmem.exists(a) || wmem[a] !== src_word(32'h0FF8 + 32'(i) * 4)) begin
                failures++;
                $display("FAIL split_data_%0d: got=%h required %h", i, wmem.exists(a) ? wmem[a] : 32'hx, src_word(32'h0FF8 + 32'(i) * 4));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        clear_logs();
        w_stall = 50;
        start_xfer(32'h4000, 32'h5000, 16'd40);
        repeat (38) @(negedge clk);
        checks++;
        if (ar_log.size() != 2 || axi.arvalid !== 1'b0 || axi.wvalid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold: ar bursts=%0d arvalid=%0b wvalid=%0b required 2, 0, 1", ar_log.size(), axi.arvalid, axi.wvalid);
        end
        wait_done("bp");
        checks++;
        if (ar_log.size() != 5 || aw_log.size() != 5) begin
            failures++;
            $display("FAIL bp_count: ar=%0d aw=%0d required 5 and 5", ar_log.size(), aw_log.size());
        end
        for (int i = 0; i < 5 && i < ar_log.size() && i < aw_log.size(); i++) begin
            checks++;
            if (ar_log[i] !== {32'h4000 + 32'(i) * 32, 8'd7} || aw_log[i] !== {32'h5000 + 32'(i) * 32, 8'd7}) begin
                failures++;
                $display("FAIL bp_burst_%0d: ar=%h aw=%h required ar=%h aw=%h", i, ar_log[i], aw_log[i],
                         {32'h4000 + 32'(i) * 32, 8'd7}, {32'h5000 + 32'(i) * 32, 8'd7});
            end
        end
        for (int i = 0; i < 40; i++) begin
            a = 32'h5000 + 32'(i) * 4;
            checks++;
            if (!wmem.exists(a) || wmem[a] !== src_word(32'h4000 + 32'(i) * 4)) begin
                failures++;
                $display("FAIL bp_data_%0d: got=%h required %h", i, wmem.exists(a) ? wmem[a] : 32'hx, src_word(32'h4000 + 32'(i) * 4));
            end
        end
    endtask

    task automatic test_bresp_error();
        clear_logs();
        err_b_idx = 1;
        start_xfer(32'h6000, 32'h7000, 16'd20);
        wait_done("err");
        checks++;
        if (error !== 1'b1 || err_resp !== 2'b10) begin
            failures++;
            $display("FAIL err_capture: error=%0b err_resp=%b required 1 and 10", error, err_resp);
        end
        checks++;
        if (aw_log.size() != 3) begin
            failures++;
            $display("FAIL err_completes: aw bursts=%0d required 3", aw_log.size());
        end
        clear_logs();
        start_xfer(32'h1000, 32'h7800, 16'd1);
        checks++;
        if (error !== 1'b0 || err_resp !== 2'b00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL err_clear_on_start: error=%0b err_resp=%b busy=%0b required 0, 00, 1", error, err_resp, busy);
        end
        wait_done("err_next");
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL err_stays_clear: error=%0b required 0", error);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        start_xfer(32'h1000, 32'h2000, 16'd40);
        repeat (6) @(negedge clk);
        reset = 1;
        #1;
        checks++;
        if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_mid: arvalid=%0b rready=%0b awvalid=%0b wvalid=%0b bready=%0b busy=%0b required 0",
                     axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, busy);
        end
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        clear_logs();
        start_xfer(32'h1100, 32'h2200, 16'd4);
        wait_done("after_reset");
        checks++;
        if (!wmem.exists(32'h220C) || wmem[32'h220C] !== src_word(32'h110C) || aw_log.size() != 1) begin
            failures++;
            $display("FAIL after_reset_data: got=%h aw=%0d required %h and 1", wmem.exists(32'h220C) ? wmem[32'h220C] : 32'hx,
                     aw_log.size(), src_word(32'h110C));
        end
    endtask

    task automatic test_busy_ignore();
        int d0;
        clear_logs();
        start_xfer(32'h1000, 32'h8000, 16'd8);
        repeat (3) @(negedge clk);
        src_addr = 32'h9000; dst_addr = 32'hA000; len_beats = 16'd4; start = 1;
        @(negedge clk);
        start = 0;
        wait_done("ignore");
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        checks++;
        if (ar_log.size() != 1 || ar_log[0] !== {32'h1000, 8'd7} || aw_log.size() != 1) begin
            failures++;
            $display("FAIL ignore_bursts: ar=%0d first=%h aw=%0d required 1, 0000100007, 1", ar_log.size(),
                     ar_log.size() ? ar_log[0] : 40'h0, aw_log.size());
        end
        checks++;
        if (busy !== 1'b0 || done_cnt != d0) begin
            failures++;
            $display("FAIL ignore_no_restart: busy=%0b extra done=%0d required 0 and 0", busy, done_cnt - d0);
        end
    endtask

    task automatic test_zero_len();
        int d0;
        clear_logs();
        d0 = done_cnt;
        start_xfer(32'h1000, 32'h2000, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_done: done=%0b busy=%0b required 1 and 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_pulse: done=%0b required 0", done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ar_log.size() != 0 || aw_log.size() != 0 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL zero_len_traffic: ar=%0d aw=%0d done pulses=%0d required 0, 0, 1", ar_log.size(), aw_log.size(), done_cnt - d0);
        end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_single();
        test_multi_burst();
        test_4k_split();
        test_backpressure();
        test_bresp_error();
        test_reset_mid();
        test_busy_ignore();
        test_zero_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end
endmodule
